// File: rtl/mat_mul_ctrl_pkg.sv
// mat_mul_ctrl_pkg: FSM state encoding and error-cause codes shared by the mat_mul job sequencer.
package mat_mul_ctrl_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/mat_mul_frame_chk.sv
// mat_mul_frame_chk: per-matrix beat counter with short/long frame detection on the tlast boundary.
module mat_mul_frame_chk
  import mat_mul_ctrl_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       clr,
  input  logic       beat,
  input  logic       tlast,
  output logic       frame_ok,
  output logic [1:0] frame_err
);
  localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
  logic [CW-1:0] cnt;
  logic at_end;
  assign at_end = cnt == CW'(SIZE - 1);
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (beat) cnt <= cnt + 1'b1;
  end
  always_comb begin
    frame_ok  = beat && at_end && tlast;
    frame_err = !beat ? ERR_NONE :
                (tlast && !at_end) ? ERR_SHORT :
                (at_end && !tlast) ? ERR_LONG : ERR_NONE;
  end
endmodule

// File: rtl/mat_mul_ctrl.sv
// mat_mul_ctrl: job sequencer for mat_mul -- frame-checked A/B load, start pulse, result tracking,
// sticky status, completion/error interrupt and performance counters for the AXI-Lite register block.
module mat_mul_ctrl
  import mat_mul_ctrl_pkg::*;
#(
  parameter int DIM_LOG   = 1,
  parameter int SIZE      = 2 ** (2 * DIM_LOG),
  parameter int CYC_WIDTH = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 cmd_go,
  input  logic                 cmd_abort,
  input  logic                 up_tvalid,
  output logic                 up_tready,
  output logic                 acc_tvalid,
  input  logic                 acc_tready,
  input  logic                 in_tlast,
  input  logic                 out_tvalid,
  input  logic                 out_tready,
  input  logic                 out_tlast,
  output logic                 sel,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 irq,
  output logic [CYC_WIDTH-1:0] cycle_cnt,
  output logic [15:0]          job_cnt
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [2:0] state, nxt;
  logic load, beat, frame_ok, go_ok, abort_ok, timeout, fin;
  logic [1:0] frame_err, ecode;
  logic [TW-1:0] tmr;
  logic [CYC_WIDTH-1:0] cyc;
  assign load       = state == S_LOAD_A || state == S_LOAD_B;
  assign acc_tvalid = up_tvalid & load;
  assign up_tready  = acc_tready & load;
  assign beat       = acc_tvalid & acc_tready;
  // any state change restarts the beat count, which covers entry to both LOAD states
  mat_mul_frame_chk #(.SIZE(SIZE)) u_frame_chk (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_aresetn(s00_axi_aresetn),
    .clr            (nxt != state),
    .beat           (beat),
    .tlast          (in_tlast),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err)
  );
  always_comb begin
    go_ok    = cmd_go && !cmd_abort && state == S_IDLE;
    abort_ok = cmd_abort && state != S_IDLE;
    timeout  = state == S_COMPUTE && !out_tvalid && tmr == TW'(TIMEOUT - 1);
    fin      = !abort_ok && out_tvalid && out_tready && out_tlast &&
               (state == S_COMPUTE || state == S_DRAIN);
    ecode    = abort_ok ? ERR_NONE : frame_err != ERR_NONE ? frame_err :
               timeout ? ERR_TIMEOUT : ERR_NONE;
    case (state)
      S_IDLE:    nxt = go_ok ? S_LOAD_A : S_IDLE;
      S_LOAD_A:  nxt = frame_ok ? S_LOAD_B : S_LOAD_A;
      S_LOAD_B:  nxt = frame_ok ? S_START : S_LOAD_B;
      S_START:   nxt = S_COMPUTE;
      S_COMPUTE: nxt = out_tvalid ? S_DRAIN : S_COMPUTE;
      S_DRAIN:   nxt = S_DRAIN;
      default:   nxt = S_IDLE;
    endcase
    if (abort_ok || ecode != ERR_NONE || fin) nxt = S_IDLE;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= S_IDLE;
      sel       <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      irq       <= 1'b0;
      tmr       <= '0;
      cyc       <= '0;
      cycle_cnt <= '0;
      job_cnt   <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt != S_IDLE;
      sel   <= nxt != S_IDLE && nxt != S_LOAD_A;
      start <= nxt == S_START;
      irq   <= fin || ecode != ERR_NONE;
      tmr   <= state == S_COMPUTE ? tmr + 1'b1 : '0;
      if (go_ok) begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
        cyc      <= '0;
      end else if (state != S_IDLE && cyc != '1) cyc <= cyc + 1'b1;
      // the final result beat cycle itself is part of the job
      if (fin) begin
        done      <= 1'b1;
        job_cnt   <= job_cnt + 1'b1;
        cycle_cnt <= cyc == '1 ? cyc : cyc + 1'b1;
      end
      if (ecode != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= ecode;
      end
    end
  end
endmodule

// File: tb/tb_mat_mul_ctrl.sv
// tb_mat_mul_ctrl: randomized scenario bench for mat_mul_ctrl (SIZE=4, TIMEOUT=16) with expectations
// derived from job-level rules: frame lengths, handshake cycle indices and job counts.
module tb_mat_mul_ctrl;
  import mat_mul_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_go = 0, cmd_abort = 0, up_tvalid = 0, acc_tready = 0, in_tlast = 0;
  logic out_tvalid = 0, out_tready = 0, out_tlast = 0;
  logic up_tready, acc_tvalid, sel, start, busy, done, err, irq;
  logic [1:0] err_code;
  logic [31:0] cycle_cnt;
  logic [15:0] job_cnt;
  int vecs = 0, errs = 0, n_start = 0, n_irq = 0, exp_jobs = 0, cyc_n = 0;

  mat_mul_ctrl #(.DIM_LOG(1), .CYC_WIDTH(32), .TIMEOUT(16)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
    .up_tvalid(up_tvalid), .up_tready(up_tready), .acc_tvalid(acc_tvalid), .acc_tready(acc_tready),
    .in_tlast(in_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
    .sel(sel), .start(start), .busy(busy), .done(done), .err(err), .err_code(err_code), .irq(irq),
    .cycle_cnt(cycle_cnt), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc_n++;
    #1;
    if (start) n_start++;
    if (irq) n_irq++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go_cmd(output int ig);
    cmd_go = 1'b1;
    ig = cyc_n;
    step();
    cmd_go = 1'b0;
  endtask

  // n beats offered with random valid/ready; tlast on beat number tl (0 = never)
  task automatic send_frame(input int n, input int tl, input bit go_pulse);
    int k;
    k = 0;
    for (int g = 0; g < 400 && k < n; g++) begin
      up_tvalid  = $urandom_range(0, 3) != 0;
      acc_tready = $urandom_range(0, 2) != 0;
      in_tlast   = k + 1 == tl;
      cmd_go     = go_pulse && g == 0;
      #1;
      vecs++;
      if (acc_tvalid !== up_tvalid || up_tready !== acc_tready) begin
        errs++;
        $display("FAIL load_handshake: acc_tvalid=%b up_tready=%b, required %b %b",
                 acc_tvalid, up_tready, up_tvalid, acc_tready);
      end
      if (up_tvalid && acc_tready) k++;
      step();
    end
    cmd_go = 0; up_tvalid = 0; in_tlast = 0;
    vecs++;
    if (k != n) begin errs++; $display("FAIL frame_budget: beats=%0d required %0d", k, n); end
  endtask

  // called in the START cycle; first result valid after lat idle COMPUTE cycles
  task automatic send_results(input int lat, output int i_f);
    int k;
    k = 0; i_f = 0;
    repeat (lat + 1) step();
    for (int g = 0; g < 400 && k < 4; g++) begin
      out_tvalid = 1'b1;
      out_tready = $urandom_range(0, 2) != 0;
      out_tlast  = k == 3;
      if (out_tready) begin k++; i_f = cyc_n; end
      step();
    end
    out_tvalid = 0; out_tready = 0; out_tlast = 0;
    vecs++;
    if (k != 4) begin errs++; $display("FAIL result_budget: beats=%0d required 4", k); end
  endtask

  task automatic test_reset();
    up_tvalid = 1; acc_tready = 1;
    repeat (3) step();
    vecs++;
    if ({sel, start, busy, done, err, err_code, irq, up_tready, acc_tvalid} !== 10'b0) begin
      errs++; $display("FAIL reset_flags: got %b required 0",
                       {sel, start, busy, done, err, err_code, irq, up_tready, acc_tvalid});
    end
    rst_n = 1'b1;
    step();
    vecs++;
    if (cycle_cnt !== 32'd0 || job_cnt !== 16'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_counters: cycle_cnt=%0d job_cnt=%0d busy=%b required 0 0 0",
                       cycle_cnt, job_cnt, busy);
    end
    up_tvalid = 0; acc_tready = 0;
  endtask

  task automatic test_job(input bit go_pulse);
    int ig, i_f, s0, q0;
    s0 = n_start; q0 = n_irq;
    go_cmd(ig);
    vecs++;
    if ({busy, sel, err, done} !== 4'b1000) begin
      errs++; $display("FAIL job_go: busy/sel/err/done=%b required 1000", {busy, sel, err, done});
    end
    send_frame(4, 4, go_pulse);
    vecs++;
    if ({busy, sel, start} !== 3'b110) begin
      errs++; $display("FAIL job_after_a: busy/sel/start=%b required 110", {busy, sel, start});
    end
    send_frame(4, 4, 1'b0);
    vecs++;
    if ({start, sel, busy} !== 3'b111) begin
      errs++; $display("FAIL job_start: start/sel/busy=%b required 111", {start, sel, busy});
    end
    send_results($urandom_range(0, 12), i_f);
    exp_jobs++;
    vecs++;
    if ({done, err, busy, irq, sel} !== 5'b10010) begin
      errs++; $display("FAIL job_done: done/err/busy/irq/sel=%b required 10010", {done, err, busy, irq, sel});
    end
    vecs++;
    if (job_cnt !== 16'(exp_jobs)) begin
      errs++; $display("FAIL job_cnt: got %0d required %0d", job_cnt, exp_jobs);
    end
    vecs++;
    if (cycle_cnt !== 32'(i_f - ig)) begin
      errs++; $display("FAIL cycle_cnt: got %0d required %0d", cycle_cnt, i_f - ig);
    end
    step();
    vecs++;
    if (irq !== 1'b0 || n_start - s0 != 1 || n_irq - q0 != 1) begin
      errs++; $display("FAIL job_pulses: irq=%b starts=%0d irqs=%0d required 0 1 1",
                       irq, n_start - s0, n_irq - q0);
    end
  endtask

  task automatic test_frame_err(input bit in_b, input int n, input int tl, input logic [1:0] code);
    int ig, s0, q0;
    s0 = n_start; q0 = n_irq;
    go_cmd(ig);
    if (in_b) send_frame(4, 4, 1'b0);
    send_frame(n, tl, 1'b0);
    acc_tready = 1'b1; up_tvalid = 1'b1;
    #1;
    vecs++;
    if ({err, err_code, irq, done, busy, up_tready, acc_tvalid} !== {1'b1, code, 1'b1, 4'b0000}) begin
      errs++; $display("FAIL frame_err: err/code/irq/done/busy/rdy/vld=%b required %b",
                       {err, err_code, irq, done, busy, up_tready, acc_tvalid}, {1'b1, code, 1'b1, 4'b0});
    end
    up_tvalid = 0; acc_tready = 0;
    step();
    vecs++;
    if (n_start != s0 || n_irq - q0 != 1 || job_cnt !== 16'(exp_jobs) || err !== 1'b1) begin
      errs++; $display("FAIL frame_err_side: starts=%0d irqs=%0d job_cnt=%0d err=%b required 0 1 %0d 1",
                       n_start - s0, n_irq - q0, job_cnt, err, exp_jobs);
    end
  endtask

  task automatic test_short();
    for (int i = 0; i < 3; i++) begin
      int tl;
      tl = $urandom_range(1, 3);
      test_frame_err(1'($urandom_range(0, 1)), tl, tl, ERR_SHORT);
    end
  endtask

  task automatic test_long();
    test_frame_err(1'b1, 4, 0, ERR_LONG);
    test_frame_err(1'b0, 4, 0, ERR_LONG);
  endtask

  task automatic test_stall();
    int ig, k, q0;
    q0 = n_irq;
    go_cmd(ig);
    send_frame(4, 4, 1'b0);
    send_frame(4, 4, 1'b0);
    for (k = 1; k <= 40; k++) begin
      step();
      if (err) break;
    end
    vecs++;
    if (k != 17) begin errs++; $display("FAIL stall_delay: err after %0d cycles required 17", k); end
    vecs++;
    if ({err_code, irq, busy, done} !== {ERR_TIMEOUT, 3'b100} || n_irq - q0 != 1) begin
      errs++; $display("FAIL stall_status: code/irq/busy/done=%b irqs=%0d required 11100 1",
                       {err_code, irq, busy, done}, n_irq - q0);
    end
  endtask

  task automatic test_abort_reset();
    int ig, q0;
    q0 = n_irq;
    go_cmd(ig);
    send_frame(4, 4, 1'b0);
    send_frame(2, 0, 1'b0);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    vecs++;
    if ({busy, irq, done, err, sel} !== 5'b0) begin
      errs++; $display("FAIL abort_status: busy/irq/done/err/sel=%b required 0", {busy, irq, done, err, sel});
    end
    cmd_go = 1'b1; cmd_abort = 1'b1;
    step();
    cmd_go = 1'b0; cmd_abort = 1'b0;
    step();
    vecs++;
    if (busy !== 1'b0 || n_irq != q0) begin
      errs++; $display("FAIL abort_go_same_cycle: busy=%b irqs=%0d required 0 0", busy, n_irq - q0);
    end
    go_cmd(ig);
    send_frame(2, 0, 1'b0);
    up_tvalid = 1'b1; acc_tready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    vecs++;
    if ({sel, start, busy, done, err, err_code, irq, up_tready, acc_tvalid} !== 10'b0 ||
        cycle_cnt !== 32'd0 || job_cnt !== 16'd0) begin
      errs++; $display("FAIL async_reset: flags=%b cycle_cnt=%0d job_cnt=%0d required 0 0 0",
                       {sel, start, busy, done, err, err_code, irq, up_tready, acc_tvalid}, cycle_cnt, job_cnt);
    end
    up_tvalid = 0; acc_tready = 0;
    exp_jobs = 0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    repeat (3) test_job(1'b0);
    test_short();
    test_job(1'b0);
    test_long();
    repeat (3) test_job(1'b1);
    test_stall();
    test_job(1'b0);
    test_abort_reset();
    test_job(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
